// File: rtl/rgb_to_hsv_pkg.sv
// Shared types and constants for the RGB/HSV conversion paths.
// Hue is on a 0..255 wheel split into six 43-code sectors.
package rgb_to_hsv_pkg;

  localparam logic [7:0] HUE_SECTOR = 8'd43;
  localparam logic [7:0] HUE_BASE_R = 8'd0;
  localparam logic [7:0] HUE_BASE_G = 8'd85;
  localparam logic [7:0] HUE_BASE_B = 8'd171;

  typedef enum logic [1:0] {
    SEC_R,
    SEC_G,
    SEC_B
  } sector_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP,
    ST_DIV_S,
    ST_DIV_H,
    ST_OUT
  } state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // grb=1 selects the WS2812B wire order {G,R,B}; grb=0 selects {R,G,B}.
  function automatic rgb_t unpack_pixel(input logic [23:0] px, input logic grb);
    rgb_t c;
    c.b = px[7:0];
    if (grb) begin
      c.g = px[23:16];
      c.r = px[15:8];
    end else begin
      c.r = px[23:16];
      c.g = px[15:8];
    end
    return c;
  endfunction

  function automatic logic [23:0] pack_pixel(input rgb_t c, input logic grb);
    return grb ? {c.g, c.r, c.b} : {c.r, c.g, c.b};
  endfunction

endpackage

// File: rtl/serial_div16by8.sv
// Serial restoring divider: 16-bit numerator by 8-bit divisor, one quotient
// bit per cycle MSB first. Caller guarantees numer < 256*divisor.
module serial_div16by8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] numer,
  input  logic [7:0]  divisor,
  output logic [7:0]  quotient,
  output logic        done
);

  logic [7:0] rem_q;
  logic [7:0] lo_q;
  logic [7:0] dsr_q;
  logic [2:0] cnt_q;
  logic       busy_q;

  logic [7:0] step_rem_in;
  logic [7:0] step_dsr;
  logic       step_bit;
  logic [8:0] trial;
  logic       step_q;
  logic [7:0] step_rem_out;

  // The start cycle already resolves the first quotient bit from the raw
  // operands, so a division occupies exactly eight clock edges.
  always_comb begin
    step_rem_in  = start ? numer[15:8] : rem_q;
    step_bit     = start ? numer[7]    : lo_q[7];
    step_dsr     = start ? divisor     : dsr_q;
    trial        = {step_rem_in, step_bit};
    step_q       = (trial >= {1'b0, step_dsr});
    step_rem_out = step_q ? 8'(trial - {1'b0, step_dsr}) : trial[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q    <= '0;
      lo_q     <= '0;
      dsr_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      quotient <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q    <= step_rem_out;
        lo_q     <= {numer[6:0], 1'b0};
        dsr_q    <= divisor;
        quotient <= {7'b0, step_q};
        cnt_q    <= 3'd7;
        busy_q   <= 1'b1;
      end else if (busy_q) begin
        rem_q    <= step_rem_out;
        lo_q     <= {lo_q[6:0], 1'b0};
        quotient <= {quotient[6:0], step_q};
        cnt_q    <= cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          busy_q <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rgb_to_hsv.sv
// Packed pixel to 8-bit H/S/V converter with valid/ready on both sides.
// Saturation and hue share one serial divider; latency is fixed at 18 cycles.
module rgb_to_hsv
  import rgb_to_hsv_pkg::*;
#(
  parameter bit GRB_ORDER = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_rgb,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  H,
  output logic [7:0]  S,
  output logic [7:0]  V
);

  state_t state_q, state_d;

  rgb_t       px_q;
  logic [7:0] v_q;
  sector_t    sec_q;
  logic       neg_q;
  logic [15:0] snum_q, hnum_q;
  logic [7:0]  sden_q, hden_q;
  logic        s_zero_q, h_zero_q;
  logic [7:0]  s_res_q;
  logic        kick_q;

  logic        accept, cap_s, load_out, div_start, div_done;
  logic [7:0]  div_quot;
  logic [15:0] div_numer;
  logic [7:0]  div_den;

  logic [7:0]  mx, mn, delta, da, db, mag;
  logic        neg;
  sector_t     sec;
  logic [15:0] snum_c, hnum_c;
  logic [7:0]  base, hue_c;

  // Channel statistics, valid while in PREP (px_q is stable then).
  always_comb begin
    mx = px_q.r;
    if (px_q.g > mx) mx = px_q.g;
    if (px_q.b > mx) mx = px_q.b;
    mn = px_q.r;
    if (px_q.g < mn) mn = px_q.g;
    if (px_q.b < mn) mn = px_q.b;
    delta = mx - mn;

    if (px_q.r == mx) begin
      sec = SEC_R;
      da  = px_q.g;
      db  = px_q.b;
    end else if (px_q.g == mx) begin
      sec = SEC_G;
      da  = px_q.b;
      db  = px_q.r;
    end else begin
      sec = SEC_B;
      da  = px_q.r;
      db  = px_q.g;
    end
    neg = (da < db);
    mag = neg ? (db - da) : (da - db);

    snum_c = {delta, 8'h00} - {8'h00, delta};
    hnum_c = 16'(mag) * 16'(HUE_SECTOR);
  end

  always_comb begin
    unique case (sec_q)
      SEC_G:   base = HUE_BASE_G;
      SEC_B:   base = HUE_BASE_B;
      default: base = HUE_BASE_R;
    endcase
    hue_c = neg_q ? (base - div_quot) : (base + div_quot);
  end

  // kick_q marks the first DIV_S cycle; otherwise the divider is fed the hue
  // operands, which are what it restarts with when saturation completes.
  assign div_numer = kick_q ? snum_q : hnum_q;
  assign div_den   = kick_q ? sden_q : hden_q;

  serial_div16by8 u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .numer    (div_numer),
    .divisor  (div_den),
    .quotient (div_quot),
    .done     (div_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    div_start = 1'b0;
    cap_s     = 1'b0;
    load_out  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = ST_PREP;
        end
      end
      ST_PREP: state_d = ST_DIV_S;
      ST_DIV_S: begin
        if (kick_q) begin
          div_start = 1'b1;
        end else if (div_done) begin
          cap_s     = 1'b1;
          div_start = 1'b1;
          state_d   = ST_DIV_H;
        end
      end
      ST_DIV_H: begin
        if (div_done) begin
          load_out = 1'b1;
          state_d  = ST_OUT;
        end
      end
      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_q     <= '0;
      v_q      <= '0;
      sec_q    <= SEC_R;
      neg_q    <= 1'b0;
      snum_q   <= '0;
      hnum_q   <= '0;
      sden_q   <= '0;
      hden_q   <= '0;
      s_zero_q <= 1'b0;
      h_zero_q <= 1'b0;
      s_res_q  <= '0;
      kick_q   <= 1'b0;
      H        <= '0;
      S        <= '0;
      V        <= '0;
    end else begin
      kick_q <= (state_q == ST_PREP);
      if (accept) px_q <= unpack_pixel(in_rgb, GRB_ORDER);
      if (state_q == ST_PREP) begin
        v_q      <= mx;
        sec_q    <= sec;
        neg_q    <= neg;
        snum_q   <= snum_c;
        sden_q   <= mx;
        hnum_q   <= hnum_c;
        hden_q   <= delta;
        s_zero_q <= (mx == 8'd0) || (delta == 8'd0);
        h_zero_q <= (delta == 8'd0);
      end
      if (cap_s) s_res_q <= s_zero_q ? '0 : div_quot;
      if (load_out) begin
        V <= v_q;
        S <= s_res_q;
        H <= h_zero_q ? '0 : hue_c;
      end
    end
  end

endmodule

// File: tb/tb_rgb_to_hsv.sv
// Directed and randomized checks of rgb_to_hsv against an arithmetic
// HSV reference model (GRB byte order).
module tb_rgb_to_hsv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [23:0] in_rgb = '0;
  logic        in_ready, out_valid;
  logic [7:0]  H, S, V;

  int checks = 0;
  int failures = 0;

  rgb_to_hsv #(.GRB_ORDER(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rgb    (in_rgb),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .H         (H),
    .S         (S),
    .V         (V)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Returns {H,S,V} for a GRB-packed pixel.
  function automatic logic [23:0] ref_hsv(input logic [23:0] px);
    int r, g, b, mx, mn, d, h, s, base, diff;
    g = int'(px[23:16]);
    r = int'(px[15:8]);
    b = int'(px[7:0]);
    mx = (r > g) ? r : g;
    mx = (b > mx) ? b : mx;
    mn = (r < g) ? r : g;
    mn = (b < mn) ? b : mn;
    d = mx - mn;
    s = (mx == 0 || d == 0) ? 0 : (255 * d) / mx;
    if (d == 0) h = 0;
    else begin
      if (r == mx)      begin base = 0;   diff = g - b; end
      else if (g == mx) begin base = 85;  diff = b - r; end
      else              begin base = 171; diff = r - g; end
      h = (base + (43 * diff) / d) & 255;
    end
    return {8'(h), 8'(s), 8'(mx)};
  endfunction

  task automatic run_pixel(input string tag, input logic [23:0] px,
                           input bit hold_ready, input int stall);
    logic [23:0] e;
    int n;
    e = ref_hsv(px);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    out_ready = hold_ready;
    in_valid  = 1'b1;
    in_rgb    = px;
    @(negedge clk);
    in_valid = 1'b0;
    in_rgb   = $urandom;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, 32'(n), 32'd18);
    check({tag, " H"}, 32'(H), 32'(e[23:16]));
    check({tag, " S"}, 32'(S), 32'(e[15:8]));
    check({tag, " V"}, 32'(V), 32'(e[7:0]));
    for (int i = 0; i < stall; i++) begin
      in_valid = (i % 2 == 0);
      in_rgb   = $urandom;
      @(negedge clk);
      check({tag, " stall out_valid"}, 32'(out_valid), 32'd1);
      check({tag, " stall in_ready"}, 32'(in_ready), 32'd0);
      check({tag, " stall HSV"}, 32'({H, S, V}), 32'(e));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, " drop out_valid"}, 32'(out_valid), 32'd0);
    check({tag, " back in_ready"}, 32'(in_ready), 32'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    logic [23:0] px;
    bit hold;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset HSV", 32'({H, S, V}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_pixel("red",   24'h00FF00, 1'b1, 0);
    check("red const H", 32'(H), 32'd0);
    run_pixel("green", 24'hFF0000, 1'b1, 0);
    check("green const H", 32'(H), 32'd85);
    run_pixel("blue",  24'h0000FF, 1'b1, 0);
    check("blue const H", 32'(H), 32'd171);
    run_pixel("grey",  24'h808080, 1'b1, 0);
    check("grey const V", 32'(V), 32'd128);
    run_pixel("black", 24'h000000, 1'b1, 0);
    run_pixel("wrap",  24'h00FF80, 1'b1, 0);
    check("wrap const H", 32'(H), 32'd235);
    run_pixel("tie",   24'hFFFF00, 1'b1, 0);
    check("tie const H", 32'(H), 32'd43);
    run_pixel("backpressure", 24'h40C020, 1'b0, 5);

    // Reset while the hue division is in flight.
    in_valid = 1'b1;
    in_rgb   = 24'h00FF80;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset out_valid", 32'(out_valid), 32'd0);
    check("midreset in_ready", 32'(in_ready), 32'd1);
    check("midreset HSV", 32'({H, S, V}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    check("midreset stale output", 32'(n), 32'd0);
    run_pixel("post_reset", 24'h00FF00, 1'b1, 0);

    for (int i = 0; i < 40; i++) begin
      px = $urandom;
      if (i % 5 == 0) px[15:8] = px[23:16];
      if (i % 7 == 0) px[7:0] = px[15:8];
      hold = 1'($urandom_range(0, 1));
      run_pixel($sformatf("rand%0d", i), px, hold, hold ? 0 : int'($urandom_range(1, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
